// File: rtl/riscv_types.sv
// Shared RISC-V core types: ALU operation encodings, divider controller states
// and the divide/remainder special-case helper.
package riscv_types;

  localparam int RV_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_DIV  = 4'd10,
    ALU_DIVU = 4'd11,
    ALU_REM  = 4'd12,
    ALU_REMU = 4'd13
  } alu_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } div_ctrl_state_t;

  // Results the divider never needs to compute: divide-by-zero and signed overflow.
  function automatic logic [RV_XLEN-1:0] div_special_result(
    input  alu_t               op,
    input  logic [RV_XLEN-1:0] a,
    input  logic [RV_XLEN-1:0] b,
    output logic               is_special
  );
    logic               signed_op;
    logic               is_rem;
    logic               ovf;
    logic [RV_XLEN-1:0] min_neg;
    min_neg    = {1'b1, {(RV_XLEN-1){1'b0}}};
    signed_op  = (op == ALU_DIV) || (op == ALU_REM);
    is_rem     = (op == ALU_REM) || (op == ALU_REMU);
    ovf        = signed_op && (a == min_neg) && (b == {RV_XLEN{1'b1}});
    is_special = (b == {RV_XLEN{1'b0}}) || ovf;
    if (b == {RV_XLEN{1'b0}}) begin
      div_special_result = is_rem ? a : {RV_XLEN{1'b1}};
    end else if (ovf) begin
      div_special_result = is_rem ? {RV_XLEN{1'b0}} : a;
    end else begin
      div_special_result = {RV_XLEN{1'b0}};
    end
  endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// Execute-stage issue/collect controller for the multi-cycle divider: issues
// work, tracks the single outstanding rd, resolves special cases and writes back.
module div_issue_ctrl
  import riscv_types::*;
#(
  parameter int XLEN    = RV_XLEN,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_div,
  input  alu_t            ex_alu_ctrl,
  input  logic [4:0]      ex_rd,
  input  logic [4:0]      ex_rs1,
  input  logic [4:0]      ex_rs2,
  input  logic            ex_use_rs1,
  input  logic            ex_use_rs2,
  input  logic [XLEN-1:0] ex_a,
  input  logic [XLEN-1:0] ex_b,
  input  logic            flush,
  output logic            div_start,
  output alu_t            div_alu_ctrl,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  output logic [4:0]      div_rd,
  output logic            div_clear,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_result,
  input  logic            wb_pipe_valid,
  output logic            wb_div_valid,
  output logic [4:0]      wb_div_rd,
  output logic [XLEN-1:0] wb_div_data,
  output logic            stall_ex,
  output logic            timeout_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  div_ctrl_state_t state_q, state_d;
  alu_t            op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [4:0]      rd_q, rd_d, busy_rd_q, busy_rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            clear_q, clear_d, tmo_q, tmo_d;
  logic            hazard, accept, is_special;
  logic [XLEN-1:0] special_res;

  // x0 is hardwired, so an outstanding write to it never blocks a reader.
  assign hazard = (busy_rd_q != 5'd0) &&
                  ((ex_use_rs1 && (ex_rs1 == busy_rd_q)) ||
                   (ex_use_rs2 && (ex_rs2 == busy_rd_q)) ||
                   (ex_rd == busy_rd_q));

  assign stall_ex     = ex_valid && (state_q != IDLE) && (ex_is_div || hazard);
  assign accept       = (state_q == IDLE) && ex_valid && ex_is_div && !flush && !stall_ex;
  assign wb_div_valid = (state_q == HOLD) && !wb_pipe_valid && (busy_rd_q != 5'd0) && !flush;
  assign wb_div_rd    = (state_q == HOLD) ? busy_rd_q : 5'd0;
  assign wb_div_data  = (state_q == HOLD) ? res_q : {XLEN{1'b0}};
  assign div_start    = (state_q == ISSUE);
  assign div_alu_ctrl = op_q;
  assign div_a        = a_q;
  assign div_b        = b_q;
  assign div_rd       = rd_q;
  assign div_clear    = clear_q;
  assign timeout_err  = tmo_q;

  always_comb begin
    is_special  = 1'b0;
    special_res = div_special_result(ex_alu_ctrl, ex_a, ex_b, is_special);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    busy_rd_d = busy_rd_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    clear_d   = 1'b0;
    tmo_d     = 1'b0;
    if (flush) begin
      state_d   = IDLE;
      busy_rd_d = 5'd0;
      res_d     = {XLEN{1'b0}};
      cnt_d     = {CNT_W{1'b0}};
      clear_d   = (state_q == ISSUE) || (state_q == WAIT);
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_d      = ex_alu_ctrl;
            a_d       = ex_a;
            b_d       = ex_b;
            rd_d      = ex_rd;
            busy_rd_d = ex_rd;
            if (is_special) begin
              res_d   = special_res;
              state_d = HOLD;
            end else begin
              state_d = ISSUE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        ISSUE: begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = WAIT;
        end
        WAIT: begin
          if (div_done) begin
            res_d   = div_result;
            cnt_d   = {CNT_W{1'b0}};
            state_d = HOLD;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            clear_d   = 1'b1;
            tmo_d     = 1'b1;
            busy_rd_d = 5'd0;
            cnt_d     = {CNT_W{1'b0}};
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          // Writes to x0 retire without ever occupying the writeback port.
          if (wb_div_valid || (busy_rd_q == 5'd0)) begin
            busy_rd_d = 5'd0;
            res_d     = {XLEN{1'b0}};
            state_d   = IDLE;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= ALU_ADD;
      a_q       <= {XLEN{1'b0}};
      b_q       <= {XLEN{1'b0}};
      rd_q      <= 5'd0;
      busy_rd_q <= 5'd0;
      res_q     <= {XLEN{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      clear_q   <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      busy_rd_q <= busy_rd_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      clear_q   <= clear_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized bench for div_issue_ctrl with a transaction-level reference model
// and a behavioural divider that answers after a random latency (or never).
module tb_div_issue_ctrl;
  import riscv_types::*;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_is_div, ex_use_rs1, ex_use_rs2, flush;
  alu_t        ex_alu_ctrl;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [31:0] ex_a, ex_b;
  logic        div_start, div_clear, div_done, wb_pipe_valid;
  alu_t        div_alu_ctrl;
  logic [31:0] div_a, div_b, div_result, wb_div_data;
  logic [4:0]  div_rd, wb_div_rd;
  logic        wb_div_valid, stall_ex, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  div_issue_ctrl #(.XLEN(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_div(ex_is_div),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2), .ex_a(ex_a), .ex_b(ex_b),
    .flush(flush), .div_start(div_start), .div_alu_ctrl(div_alu_ctrl),
    .div_a(div_a), .div_b(div_b), .div_rd(div_rd), .div_clear(div_clear),
    .div_done(div_done), .div_result(div_result), .wb_pipe_valid(wb_pipe_valid),
    .wb_div_valid(wb_div_valid), .wb_div_rd(wb_div_rd), .wb_div_data(wb_div_data),
    .stall_ex(stall_ex), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural RISC-V M-extension divide/remainder semantics.
  function automatic logic [31:0] ref_div(alu_t op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      ALU_DIV:  return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      ALU_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM:  return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      ALU_REMU: return (b == 32'd0) ? a : a % b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic bit ref_special(alu_t op, logic [31:0] a, logic [31:0] b);
    return (b == 32'd0) ||
           (((op == ALU_DIV) || (op == ALU_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 4))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd5;
      3:       return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic alu_t pick_div_op();
    case ($urandom_range(0, 3))
      0:       return ALU_DIV;
      1:       return ALU_DIVU;
      2:       return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

  function automatic logic [31:0] pick_a();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'd100;
      2:       return 32'd5;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] pick_b();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd7;
      3:       return 32'($urandom_range(1, 255));
      default: return $urandom;
    endcase
  endfunction

  // Reference model: one outstanding division described by its phase flags.
  bit          m_issue, m_wait, m_hold, m_clear_pend, m_tmo_pend;
  int          m_wait_n;
  alu_t        m_op;
  logic [31:0] m_a, m_b, m_exp;
  logic [4:0]  m_rd;
  // Behavioural divider.
  bit          dv_active;
  int          dv_left;
  logic [31:0] dv_res;

  initial begin
    bit          idle, haz, n_clear, n_tmo;
    logic [31:0] exp_val;
    rst = 1'b1; ex_valid = 1'b1; ex_is_div = 1'b1; ex_alu_ctrl = ALU_DIV;
    ex_rd = 5'd5; ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_use_rs1 = 1'b0; ex_use_rs2 = 1'b0;
    ex_a = 32'd100; ex_b = 32'd7; flush = 1'b0; div_done = 1'b0; div_result = 32'd0;
    wb_pipe_valid = 1'b0;
    m_issue = 0; m_wait = 0; m_hold = 0; m_clear_pend = 0; m_tmo_pend = 0; m_wait_n = 0;
    m_op = ALU_ADD; m_a = 32'd0; m_b = 32'd0; m_exp = 32'd0; m_rd = 5'd0;
    dv_active = 0; dv_left = 0; dv_res = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_start",  32'(div_start), 32'd0);
    check_eq("rst_clear",  32'(div_clear), 32'd0);
    check_eq("rst_tmo",    32'(timeout_err), 32'd0);
    check_eq("rst_wbv",    32'(wb_div_valid), 32'd0);
    check_eq("rst_wbdata", wb_div_data, 32'd0);
    check_eq("rst_stall",  32'(stall_ex), 32'd0);
    check_eq("rst_diva",   div_a, 32'd0);
    check_eq("rst_divrd",  32'(div_rd), 32'd0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst           = (cyc == 0) || (cyc == 2000) || (cyc == 2001);
      ex_valid      = ($urandom_range(0, 9) < 7);
      ex_is_div     = ($urandom_range(0, 2) == 0);
      ex_alu_ctrl   = ex_is_div ? pick_div_op() : ALU_ADD;
      ex_rd         = pick_reg();
      ex_rs1        = pick_reg();
      ex_rs2        = pick_reg();
      ex_use_rs1    = ($urandom_range(0, 1) == 1);
      ex_use_rs2    = ($urandom_range(0, 1) == 1);
      ex_a          = pick_a();
      ex_b          = pick_b();
      flush         = ($urandom_range(0, 99) < 3);
      wb_pipe_valid = ($urandom_range(0, 9) < 4);
      if (dv_active && (dv_left == 0)) begin
        div_done = 1'b1; div_result = dv_res;
      end else if (!dv_active && ($urandom_range(0, 99) < 4)) begin
        div_done = 1'b1; div_result = $urandom;
      end else begin
        div_done = 1'b0; div_result = $urandom;
      end
      #1;
      idle = !m_issue && !m_wait && !m_hold;
      haz  = (m_rd != 5'd0) && ((ex_use_rs1 && (ex_rs1 == m_rd)) ||
                                (ex_use_rs2 && (ex_rs2 == m_rd)) || (ex_rd == m_rd));
      check_eq("div_start", 32'(div_start), 32'(m_issue));
      check_eq("div_clear", 32'(div_clear), 32'(m_clear_pend));
      check_eq("timeout_err", 32'(timeout_err), 32'(m_tmo_pend));
      check_eq("stall_ex", 32'(stall_ex), 32'(ex_valid && !idle && (ex_is_div || haz)));
      check_eq("wb_div_valid", 32'(wb_div_valid),
               32'(m_hold && !wb_pipe_valid && (m_rd != 5'd0) && !flush));
      check_eq("wb_div_rd", 32'(wb_div_rd), m_hold ? 32'(m_rd) : 32'd0);
      exp_val = m_hold ? m_exp : 32'd0;
      check_eq("wb_div_data", wb_div_data, exp_val);
      if (m_issue || m_wait) begin
        check_eq("div_a", div_a, m_a);
        check_eq("div_b", div_b, m_b);
        check_eq("div_rd", 32'(div_rd), 32'(m_rd));
        check_eq("div_op", 32'(div_alu_ctrl), 32'(m_op));
      end

      n_clear = 0;
      n_tmo   = 0;
      if (rst) begin
        m_issue = 0; m_wait = 0; m_hold = 0; m_rd = 5'd0; dv_active = 0;
      end else if (flush) begin
        n_clear = m_issue || m_wait;
        m_issue = 0; m_wait = 0; m_hold = 0; m_rd = 5'd0; dv_active = 0;
      end else if (idle) begin
        if (ex_valid && ex_is_div) begin
          m_op = ex_alu_ctrl; m_a = ex_a; m_b = ex_b; m_rd = ex_rd;
          m_exp = ref_div(ex_alu_ctrl, ex_a, ex_b);
          if (ref_special(ex_alu_ctrl, ex_a, ex_b)) m_hold = 1;
          else m_issue = 1;
        end
      end else if (m_issue) begin
        m_issue = 0; m_wait = 1; m_wait_n = 0;
        dv_active = 1;
        dv_left   = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 40));
        dv_res    = ref_div(m_op, m_a, m_b);
      end else if (m_wait) begin
        if (div_done) begin
          m_wait = 0; m_hold = 1; dv_active = 0;
        end else if (m_wait_n == TMO - 1) begin
          n_clear = 1; n_tmo = 1; m_wait = 0; m_rd = 5'd0; dv_active = 0;
        end else begin
          m_wait_n++;
          dv_left--;
        end
      end else if (m_hold) begin
        if ((m_rd == 5'd0) || !wb_pipe_valid) begin
          m_hold = 0; m_rd = 5'd0;
        end
      end
      m_clear_pend = n_clear;
      m_tmo_pend   = n_tmo;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Execute-stage initiator and collector for the multi-cycle integer divider. It accepts DIV/DIVU/REM/REMU from execute and issues a one-cycle start to the divider. It tracks the single outstanding destination register and stalls dependent or structurally conflicting instructions. It applies the RISC-V special-case results without invoking the divider, then buffers the result and arbitrates it onto the shared writeback port.

Parameters:
XLEN, 32, operand/result width
TIMEOUT, 64, max cycles in WAIT before watchdog abort

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
ex_valid  in  1  execute-stage instruction valid
ex_is_div  in  1  instruction is DIV/DIVU/REM/REMU
ex_alu_ctrl  in  alu_t  operation encoding
ex_rd / ex_rs1 / ex_rs2  in  5 each  register indices
ex_use_rs1 / ex_use_rs2  in  1 each  source actually read
ex_a / ex_b  in  XLEN each  dividend / divisor
flush  in  1  pipeline flush
div_start  out  1  start pulse to divider
div_alu_ctrl  out  alu_t  registered op
div_a / div_b  out  XLEN each  registered operands
div_rd  out  5  registered destination
div_clear  out  1  abort pulse to divider
div_done  in  1  divider result valid
div_result  in  XLEN  divider result
wb_pipe_valid  in  1  main pipeline uses writeback this cycle
wb_div_valid  out  1  divider result written this cycle
wb_div_rd  out  5  writeback destination
wb_div_data  out  XLEN  writeback data
stall_ex  out  1  hold execute stage
timeout_err  out  1  one-cycle watchdog pulse

Behaviour:
- Clock and reset: one clock, clk; synchronous active-high reset, rst.
- Reset values: state IDLE; all registered outputs 0; busy clear; counter 0.
- States:
  - IDLE: new division is accepted only in IDLE.
  - ISSUE: lasts 1 cycle; div_start=1.
  - WAIT: waits for the divider.
  - HOLD: result buffered, waiting for writeback.
- Accept condition: IDLE & ex_valid & ex_is_div & !flush & !stall_ex. On accept, latch op/a/b/rd and set busy_rd=ex_rd.
- Special cases are decided at accept:
  - b==0: DIV/DIVU -> all ones; REM/REMU -> a.
  - Signed op with a==1<<(XLEN-1) and b==all ones: DIV -> a; REM -> 0.
  - Special case -> HOLD directly. div_start never asserted. Result available for writeback the next cycle.
- Normal accept -> ISSUE. div_start high exactly that one cycle; div_a/div_b/div_alu_ctrl/div_rd stable from ISSUE until leaving WAIT. Then -> WAIT.
- WAIT:
  - Counter increments each cycle.
  - div_done sampled only in WAIT. On div_done, capture div_result -> HOLD, counter cleared.
  - If the counter reaches TIMEOUT-1 without div_done: div_clear=1 and timeout_err=1 for one cycle, -> IDLE, result discarded.
- HOLD:
  - wb_div_valid = !wb_pipe_valid & busy_rd!=0 (combinational). Main pipeline always has priority.
  - Retire (-> IDLE, busy clear) in the cycle wb_div_valid=1.
  - If busy_rd==0, retire on the first HOLD cycle with no writeback.
  - wb_div_rd/wb_div_data hold the buffered values while in HOLD; 0 otherwise.
- Latency: div_done at cycle t -> earliest wb_div_valid at t+1. Special case accepted at t -> earliest writeback at t+1.
- stall_ex (combinational) = ex_valid & state!=IDLE & (ex_is_div | hazard).
  - hazard when busy_rd!=0 and any of: (ex_use_rs1 & ex_rs1==busy_rd), (ex_use_rs2 & ex_rs2==busy_rd), or ex_rd==busy_rd (WAW).
  - x0 never causes a hazard.
- flush (highest priority, any state):
  - Next state IDLE, busy cleared, buffered result discarded.
  - wb_div_valid forced 0 in the flush cycle.
  - div_clear pulses 1 cycle if the state was ISSUE or WAIT.
  - flush with div_done: flush wins. flush with an accept request: no accept.
- A div_done arriving outside WAIT (e.g., the pulse the divider emits on clear) is ignored.
- Reset mid-operation behaves identically to power-on reset; no div_clear is generated.

Decomposition:
- alu_t and the DIV/DIVU/REM/REMU encodings come from riscv_types.
- Add to riscv_types: enum div_ctrl_state_t {IDLE, ISSUE, WAIT, HOLD}.
- Add a function div_special_result(op, a, b, out is_special), shared with verification models.
- No sub-module; the hazard compare stays inline.

Test Plan:
- DIV a=100, b=7 with divider model returning 14 after 33 cycles -> div_start one cycle after accept; wb_div_valid with wb_div_data=14 on the cycle after div_done; stall_ex drops on the retire cycle.
- DIVU a=5, b=0 -> no div_start; next cycle wb_div_data=0xFFFFFFFF. REM a=5, b=0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Divider busy with rd=x5; execute an ADD reading rs2=x5 -> stall_ex=1 until retire. Same scenario with rd=x0 -> no stall from the ADD; a second DIV stalls structurally.
- div_done while wb_pipe_valid=1 for 3 cycles -> wb_div_valid stays 0 and data is held; asserted on the 4th cycle with the correct rd/data.
- flush during WAIT with div_done in the same cycle -> div_clear pulse, no writeback, state IDLE; a new DIV is accepted the next cycle.
- Divider never returns (TIMEOUT=64) -> div_clear and timeout_err pulse together 64 cycles after entering WAIT; state IDLE; stall_ex released.
